// File: rtl/mem_access_unit.sv
// Initiator-side load/store engine for the rom_inf memory protocol: one request in,
// one memory access out, one extended/errored response back per transaction.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [1:0]  resp_err_code,
   output logic        busy,
   output logic        rd_en,
   output logic [31:0] rd_addr,
   output logic [2:0]  rd_byte_num,
   input  logic [31:0] rd_data,
   input  logic        rd_done,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic [2:0]  wr_byte_num,
   input  logic        wr_done,
   output logic [1:0]  dbg_state_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_SIZE    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

   logic [1:0]  state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        en_q, en_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [1:0]  code_q, code_d;

   logic        misaligned;
   logic        done;
   logic [15:0] cnt_inc;
   logic [31:0] load_ext;
   logic [2:0]  byte_num;

   // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
   // a response transfers on a rising edge where resp_valid && resp_ready.
   assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                       ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
   assign done    = we_q ? wr_done : rd_done;
   assign cnt_inc = cnt_q + 16'd1;

   // Bytes above the access width are stale on rd_data, so only the low lanes are kept.
   always_comb begin
      case (size_q)
         2'd0:    load_ext = {{24{~uns_q & rd_data[7]}},  rd_data[7:0]};
         2'd1:    load_ext = {{16{~uns_q & rd_data[15]}}, rd_data[15:0]};
         default: load_ext = rd_data;
      endcase
   end

   always_comb begin
      case (size_q)
         2'd0:    byte_num = 3'd1;
         2'd1:    byte_num = 3'd2;
         default: byte_num = 3'd4;
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      en_d    = en_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      code_d  = code_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = '0;
               rdata_d = '0;
               err_d   = 1'b0;
               code_d  = ERR_NONE;
               if (req_size == 2'd3) begin
                  err_d   = 1'b1;
                  code_d  = ERR_SIZE;
                  state_d = S_RESP;
               end else if (misaligned) begin
                  err_d   = 1'b1;
                  code_d  = ERR_MISALIGN;
                  state_d = S_RESP;
               end else begin
                  en_d    = 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end
         // done is a level that may still be high from a previous access, so ISSUE ignores it.
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (done) begin
               en_d    = 1'b0;
               rdata_d = we_q ? 32'd0 : load_ext;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TIMEOUT_LIM) begin
                  en_d    = 1'b0;
                  err_d   = 1'b1;
                  code_d  = ERR_TIMEOUT;
                  rdata_d = '0;
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               cnt_d   = '0;
               rdata_d = '0;
               err_d   = 1'b0;
               code_d  = ERR_NONE;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         en_q    <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         en_q    <= en_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   assign req_ready     = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign resp_valid    = (state_q == S_RESP);
   assign resp_rdata    = rdata_q;
   assign resp_err      = err_q;
   assign resp_err_code = code_q;
   assign dbg_state_o   = state_q;

   assign rd_en       = en_q & ~we_q;
   assign rd_addr     = rd_en ? addr_q : 32'd0;
   assign rd_byte_num = rd_en ? byte_num : 3'd0;
   assign wr_en       = en_q & we_q;
   assign wr_addr     = wr_en ? addr_q : 32'd0;
   assign wr_data     = wr_en ? wdata_q : 32'd0;
   assign wr_byte_num = wr_en ? byte_num : 3'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a rom_inf responder with stale upper read lanes, a byte-array
// reference memory, directed scenarios and a randomized load/store sequence.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err_code;
   logic        busy;
   logic        rd_en, rd_done;
   logic [31:0] rd_addr, rd_data;
   logic [2:0]  rd_byte_num;
   logic        wr_en, wr_done;
   logic [31:0] wr_addr, wr_data;
   logic [2:0]  wr_byte_num;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem[0:255];
   logic [7:0] ref_mem[0:255];
   int   lat_cfg = 1;
   logic hang = 1'b0;
   int   rsp_cnt = 0;
   int   en_cycles = 0;
   logic both_seen = 1'b0;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .resp_err_code(resp_err_code), .busy(busy),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_byte_num(rd_byte_num), .rd_data(rd_data),
      .rd_done(rd_done),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_num(wr_byte_num),
      .wr_done(wr_done),
      .dbg_state_o(dbg_state)
   );

   // Responder: raises done lat_cfg cycles into an access and keeps it as a level until en drops.
   always @(negedge clk) begin
      if (rst || !(rd_en || wr_en)) begin
         rd_done = 1'b0;
         wr_done = 1'b0;
         rsp_cnt = 0;
      end else if (!(rd_done || wr_done)) begin
         rsp_cnt++;
         rd_data = $urandom;
         if (!hang && rsp_cnt >= lat_cfg) begin
            if (rd_en) begin
               for (int i = 0; i < 4; i++)
                  if (i < int'(rd_byte_num)) rd_data[8*i +: 8] = mem[8'(rd_addr + 32'(i))];
               rd_done = 1'b1;
            end else begin
               for (int i = 0; i < 4; i++)
                  if (i < int'(wr_byte_num)) mem[8'(wr_addr + 32'(i))] = wr_data[8*i +: 8];
               wr_done = 1'b1;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rd_en && wr_en) both_seen <= 1'b1;
      if (rd_en || wr_en) en_cycles <= en_cycles + 1;
   end

   function automatic int width_of(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                              input logic uns);
      longint v = 0;
      int     n = width_of(sz);
      for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[8'(a + 32'(i))]);
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   function automatic logic [1:0] model_code(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd3) return 2'd2;
      if ((sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0)) return 2'd1;
      return 2'd0;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      for (int i = 0; i < width_of(sz); i++) ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
   endtask

   // Issues one request, reports response fields, edges from accept to resp_valid
   // (-1 if none) and whether the response stayed stable while held for 'hold' cycles.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input int hold,
                         output logic [31:0] rdata, output logic err, output logic [1:0] code,
                         output int lat, output logic stable);
      @(negedge clk);
      req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 50) begin
         @(posedge clk);
         #1 lat++;
      end
      if (resp_valid !== 1'b1) lat = -1;
      rdata = resp_rdata; err = resp_err; code = resp_err_code;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (resp_valid !== 1'b1 || resp_rdata !== rdata || resp_err !== err ||
             resp_err_code !== code || req_ready !== 1'b0) stable = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || rd_en !== 1'b0 ||
          wr_en !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 || resp_err_code !== 2'd0) begin
         bad++;
         $display("FAIL reset_state: ready=%b busy=%b rv=%b rd_en=%b wr_en=%b rdata=%h err=%b code=%0d, need 1 0 0 0 0 0 0 0",
                  req_ready, busy, resp_valid, rd_en, wr_en, resp_rdata, resp_err, resp_err_code);
      end
   endtask

   task automatic test_word_load();
      logic [31:0] rd; logic e; logic [1:0] c; int lat; logic st;
      lat_cfg = 1;
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, e, c, lat, st);
      total++;
      if (rd !== 32'h1234FF80 || e !== 1'b0 || lat !== 2) begin
         bad++;
         $display("FAIL lw_0x10: rdata=%h err=%b lat=%0d, need 1234ff80 0 2", rd, e, lat);
      end
   endtask

   task automatic test_extend();
      logic [31:0] rd; logic e; logic [1:0] c; int lat; logic st;
      logic [1:0]  sz [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
      logic        un [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] ad [5] = '{32'h10, 32'h10, 32'h12, 32'h10, 32'h10};
      logic [31:0] ex [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00001234, 32'hFFFFFF80, 32'h0000FF80};
      for (int i = 0; i < 5; i++) begin
         lat_cfg = i + 1;
         do_req(1'b0, sz[i], un[i], ad[i], 32'h0, 0, rd, e, c, lat, st);
         total++;
         if (rd !== ex[i] || e !== 1'b0) begin
            bad++;
            $display("FAIL extend_%0d: rdata=%h err=%b, need %h 0", i, rd, e, ex[i]);
         end
      end
   endtask

   task automatic test_store_load();
      logic [31:0] rd; logic e; logic [1:0] c; int lat; logic st;
      lat_cfg = 2;
      do_req(1'b1, 2'd1, 1'b0, 32'h20, 32'hDEADBEEF, 1, rd, e, c, lat, st);
      model_store(32'h20, 2'd1, 32'hDEADBEEF);
      total++;
      if (rd !== 32'd0 || e !== 1'b0 || lat !== 2 || st !== 1'b1) begin
         bad++;
         $display("FAIL sh_0x20: rdata=%h err=%b lat=%0d stable=%b, need 0 0 2 1", rd, e, lat, st);
      end
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, rd, e, c, lat, st);
      total++;
      if (rd !== 32'h0000BEEF || e !== 1'b0) begin
         bad++;
         $display("FAIL lw_0x20: rdata=%h err=%b, need 0000beef 0", rd, e);
      end
      total++;
      if (both_seen !== 1'b0) begin
         bad++;
         $display("FAIL en_exclusive: both_seen=%b, need 0", both_seen);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic e; logic [1:0] c; int lat; logic st; int en0;
      logic [1:0]  sz [4] = '{2'd2, 2'd3, 2'd1, 2'd3};
      logic [31:0] ad [4] = '{32'h21, 32'h10, 32'h13, 32'h13};
      logic [1:0]  ex [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
      for (int i = 0; i < 4; i++) begin
         en0 = en_cycles;
         do_req(1'(i % 2), sz[i], 1'b0, ad[i], 32'hFFFF_FFFF, 3, rd, e, c, lat, st);
         total++;
         if (e !== 1'b1 || c !== ex[i] || rd !== 32'd0 || lat !== 0 || st !== 1'b1 ||
             en_cycles !== en0) begin
            bad++;
            $display("FAIL reject_%0d: err=%b code=%0d rdata=%h lat=%0d stable=%b en_cycles=%0d, need 1 %0d 0 0 1 0",
                     i, e, c, rd, lat, st, en_cycles - en0, ex[i]);
         end
      end
   endtask

   task automatic test_timeout();
      logic [31:0] rd; logic e; logic [1:0] c; int lat; logic st; int en0;
      hang = 1'b1;
      en0 = en_cycles;
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, e, c, lat, st);
      total++;
      if (e !== 1'b1 || c !== 2'd3 || rd !== 32'd0 || lat !== 5 || en_cycles - en0 !== 5 ||
          rd_en !== 1'b0) begin
         bad++;
         $display("FAIL timeout: err=%b code=%0d rdata=%h lat=%0d en_cycles=%0d rd_en=%b, need 1 3 0 5 5 0",
                  e, c, rd, lat, en_cycles - en0, rd_en);
      end
      hang = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] rd; logic e; logic [1:0] c; int lat; logic st;
      hang = 1'b1;
      @(negedge clk);
      req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || rd_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 ||
          dbg_state !== 2'd0) begin
         bad++;
         $display("FAIL rst_mid_op: busy=%b rd_en=%b rv=%b ready=%b state=%0d, need 0 0 0 1 0",
                  busy, rd_en, resp_valid, req_ready, dbg_state);
      end
      @(negedge clk) rst = 1'b0;
      hang = 1'b0;
      lat_cfg = 1;
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, e, c, lat, st);
      total++;
      if (rd !== 32'h1234FF80 || e !== 1'b0 || lat !== 2) begin
         bad++;
         $display("FAIL after_rst: rdata=%h err=%b lat=%0d, need 1234ff80 0 2", rd, e, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, a, wd, exp_rd; logic e; logic [1:0] c, sz, exp_c; int lat, exp_lat, hold;
      logic st, we, uns;
      for (int n = 0; n < 40; n++) begin
         we   = 1'($urandom_range(0, 1));
         sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         uns  = 1'($urandom_range(0, 1));
         a    = 32'($urandom_range(0, 127));
         wd   = $urandom;
         hold = $urandom_range(0, 2);
         lat_cfg = $urandom_range(1, 4);
         exp_c = model_code(sz, a);
         exp_rd = 32'd0;
         exp_lat = (exp_c != 2'd0) ? 0 : ((lat_cfg > 2) ? lat_cfg : 2);
         if (exp_c == 2'd0) begin
            if (we) model_store(a, sz, wd);
            else exp_rd = model_load(a, sz, uns);
         end
         do_req(we, sz, uns, a, wd, hold, rd, e, c, lat, st);
         total++;
         if (rd !== exp_rd || c !== exp_c || e !== (exp_c != 2'd0) || lat !== exp_lat || st !== 1'b1) begin
            bad++;
            $display("FAIL rand_%0d: we=%b sz=%0d uns=%b addr=%h got rdata=%h err=%b code=%0d lat=%0d stable=%b, need %h %b %0d %0d 1",
                     n, we, sz, uns, a, rd, e, c, lat, st, exp_rd, exp_c != 2'd0, exp_c, exp_lat);
         end
      end
      total++;
      if (both_seen !== 1'b0) begin
         bad++;
         $display("FAIL en_exclusive_rand: both_seen=%b, need 0", both_seen);
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      rd_data = '0; rd_done = 1'b0; wr_done = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[16'h10] = 8'h80; mem[16'h11] = 8'hFF; mem[16'h12] = 8'h34; mem[16'h13] = 8'h12;
      for (int i = 32'h20; i < 32'h24; i++) mem[i] = 8'h00;
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_word_load();
      test_extend();
      test_store_load();
      test_errors();
      test_timeout();
      test_reset_mid_op();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
